// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined signed fixed-point complex multiplier (optionally A*conj(B)).
// Stall-all valid/ready handshake; rounding, saturation/wrap and overflow flags on the output stage.
module complex_mul_pipe #(
    parameter int W     = 8,
    parameter int FRAC  = 4,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] aj,
    input  logic [W-1:0] b,
    input  logic [W-1:0] bj,
    input  logic         conj_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [W-1:0] cj,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         clr
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 2;

    localparam logic signed [SW-1:0] MAX_S = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] RND_S = (ROUND != 0) ?
        ({{(SW-1){1'b0}}, 1'b1} << (FRAC - 1)) : {SW{1'b0}};

    // Round, shift and range-limit one component; returns {overflow, value}.
    function automatic logic [W:0] scale_f(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] y;
        logic                 o;
        logic [W-1:0]         v;
        y = (x + RND_S) >>> FRAC;
        if (y > MAX_S) begin
            o = 1'b1;
            v = (SAT != 0) ? MAX_S[W-1:0] : y[W-1:0];
        end else if (y < MIN_S) begin
            o = 1'b1;
            v = (SAT != 0) ? MIN_S[W-1:0] : y[W-1:0];
        end else begin
            o = 1'b0;
            v = y[W-1:0];
        end
        return {o, v};
    endfunction

    logic                 adv_s;
    logic                 v1_r, v2_r;
    logic                 conj1_r, conj2_r;
    logic signed [W-1:0]  a_r, aj_r, b_r, bj_r;
    logic signed [PW-1:0] p_ab_r, p_ajbj_r, p_abj_r, p_ajb_r;
    logic signed [SW-1:0] re_s, im_s;
    logic [W-1:0]         c_s, cj_s;
    logic                 ovf_re_s, ovf_im_s;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            conj1_r <= 1'b0;
            a_r     <= '0;
            aj_r    <= '0;
            b_r     <= '0;
            bj_r    <= '0;
        end else if (adv_s) begin
            v1_r    <= in_valid;
            conj1_r <= conj_b;
            a_r     <= a;
            aj_r    <= aj;
            b_r     <= b;
            bj_r    <= bj;
        end
    end

    // Stage 2: four full-precision partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            conj2_r  <= 1'b0;
            p_ab_r   <= '0;
            p_ajbj_r <= '0;
            p_abj_r  <= '0;
            p_ajb_r  <= '0;
        end else if (adv_s) begin
            v2_r     <= v1_r;
            conj2_r  <= conj1_r;
            p_ab_r   <= PW'(a_r) * PW'(b_r);
            p_ajbj_r <= PW'(aj_r) * PW'(bj_r);
            p_abj_r  <= PW'(a_r) * PW'(bj_r);
            p_ajb_r  <= PW'(aj_r) * PW'(b_r);
        end
    end

    // Stage 3 combinational: sums are re-signed rather than negating operands, so -2^(W-1) is safe.
    always_comb begin
        re_s     = '0;
        im_s     = '0;
        c_s      = '0;
        cj_s     = '0;
        ovf_re_s = 1'b0;
        ovf_im_s = 1'b0;
        if (conj2_r) begin
            re_s = SW'(p_ab_r) + SW'(p_ajbj_r);
            im_s = SW'(p_ajb_r) - SW'(p_abj_r);
        end else begin
            re_s = SW'(p_ab_r) - SW'(p_ajbj_r);
            im_s = SW'(p_abj_r) + SW'(p_ajb_r);
        end
        {ovf_re_s, c_s}  = scale_f(re_s);
        {ovf_im_s, cj_s} = scale_f(im_s);
    end

    // Stage 3 register: results only change when a valid sample advances into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            cj        <= '0;
            ovf       <= 1'b0;
        end else if (adv_s) begin
            out_valid <= v2_r;
            if (v2_r) begin
                c   <= c_s;
                cj  <= cj_s;
                ovf <= ovf_re_s | ovf_im_s;
            end
        end
    end

    // Sticky overflow; clear wins over a coincident set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule
